// File: rtl/sram_bw.sv
// sram_bw: byte-writable single-port SRAM; SRAM_BW_INIT_EN adds an INIT_VAL sweep after reset.
// Latency: dout = mem[adr_r], valid one cycle after acceptance; rvalid flags accepted reads.
// Backpressure: rdy is low until the FSM is READY; only en && rdy edges are accepted.
module sram_bw #(
  parameter int DW = 32,
  parameter int AW = 14,
  parameter int ALSB = 2,
  parameter logic [DW-1:0] INIT_VAL = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [DW/8-1:0] we,
  input  logic [31:0]     adr,
  input  logic [DW-1:0]   din,
  output logic [DW-1:0]   dout,
  output logic            rdy,
  output logic            rvalid
);
  localparam int NB = DW / 8;

  typedef enum logic {INIT, READY} state_t;

  state_t        state, state_nxt;
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [AW-1:0] idx;
  logic [AW-1:0] adr_r;
  logic          acc;
  logic          unused_adr;

  // Upper/lower address bits are don't-care, so words alias modulo the depth.
  assign idx        = adr[ALSB+AW-1:ALSB];
  assign unused_adr = ^adr;

  assign rdy  = (state == READY);
  assign acc  = en && rdy && !rst;
  assign dout = mem[adr_r];

`ifdef SRAM_BW_INIT_EN
  localparam logic [AW-1:0] LAST = '1;

  logic [AW-1:0] cnt;
  logic          sweep;

  assign sweep = (state == INIT) && !rst;

  // Counter parks on the last word instead of wrapping once READY is reached.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (sweep && cnt != LAST) begin
      cnt <= cnt + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    if (state == INIT && cnt == LAST) begin
      state_nxt = READY;
    end
  end
`else
  localparam logic [DW-1:0] unused_init_val = INIT_VAL;

  always_comb begin
    state_nxt = state;
    if (state == INIT) begin
      state_nxt = READY;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= INIT;
    end else begin
      state <= state_nxt;
    end
  end

  // Memory has no reset; sweep and access writes are exclusive by FSM state.
  always_ff @(posedge clk) begin
`ifdef SRAM_BW_INIT_EN
    if (sweep) begin
      mem[cnt] <= INIT_VAL;
    end
`endif
    if (acc) begin
      for (int i = 0; i < NB; i++) begin
        if (we[i]) begin
          mem[idx][8*i +: 8] <= din[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      adr_r  <= '0;
      rvalid <= 1'b0;
    end else begin
      rvalid <= acc && (we == '0);
      if (acc) begin
        adr_r <= idx;
      end
    end
  end

endmodule

// File: tb/tb_sram_bw.sv
// Scoreboard bench for sram_bw (AW=4); init-sweep scenarios build only with SRAM_BW_INIT_EN.
`timescale 1ns/1ps
module tb_sram_bw;
  localparam int DW = 32;
  localparam int AW = 4;
  localparam int ALSB = 2;
  localparam logic [DW-1:0] IV = 32'hA5C3_3C5A;
`ifdef SRAM_BW_INIT_EN
  localparam int INIT_CYC = 16;
`else
  localparam int INIT_CYC = 1;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic [3:0]    we;
  logic [31:0]   adr;
  logic [31:0]   din;
  logic [31:0]   dout;
  logic          rdy;
  logic          rvalid;

  sram_bw #(.DW(DW), .AW(AW), .ALSB(ALSB), .INIT_VAL(IV)) dut (
    .clk(clk), .rst(rst), .en(en), .we(we), .adr(adr),
    .din(din), .dout(dout), .rdy(rdy), .rvalid(rvalid)
  );

  always #5 clk = ~clk;

  int          n_pass = 0;
  int          n_total = 0;
  logic [31:0] model [16];
  logic [31:0] exp_q [$];

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [3:0] w, input logic [31:0] d);
    en = 1'b1; we = w; adr = a; din = d;
    for (int i = 0; i < 4; i++)
      if (w[i]) model[a[5:2]][8*i +: 8] = d[8*i +: 8];
    step;
    en = 1'b0; we = 4'h0;
    n_total++;
    if (rvalid !== 1'b0) $display("FAIL wr_rvalid adr=%h got=%b exp=0", a, rvalid);
    else n_pass++;
  endtask

  task automatic do_read(input logic [31:0] a, input string tag);
    logic [31:0] e;
    en = 1'b1; we = 4'h0; adr = a;
    exp_q.push_back(model[a[5:2]]);
    step;
    en = 1'b0;
    n_total++;
    if (rvalid !== 1'b1) $display("FAIL %s_rvalid got=%b exp=1", tag, rvalid);
    else n_pass++;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      n_total++;
      if (dout !== e) $display("FAIL %s_dout adr=%h got=%h exp=%h", tag, a, dout, e);
      else n_pass++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; en = 1'b0; we = 4'h0; adr = '0; din = '0;
    repeat (3) step;
    n_total++;
    if (rdy !== 1'b0) $display("FAIL reset_rdy got=%b exp=0", rdy);
    else n_pass++;
    n_total++;
    if (rvalid !== 1'b0) $display("FAIL reset_rvalid got=%b exp=0", rvalid);
    else n_pass++;
  endtask

  task automatic test_init;
    rst = 1'b0;
    for (int i = 0; i < INIT_CYC; i++) begin
      n_total++;
      if (rdy !== 1'b0) $display("FAIL init_rdy_low cyc=%0d got=%b exp=0", i, rdy);
      else n_pass++;
      step;
    end
    n_total++;
    if (rdy !== 1'b1) $display("FAIL init_rdy_high got=%b exp=1", rdy);
    else n_pass++;
`ifdef SRAM_BW_INIT_EN
    n_total++;
    if (dout !== IV) $display("FAIL init_dout0 got=%h exp=%h", dout, IV);
    else n_pass++;
    for (int w = 0; w < 16; w++) model[w] = IV;
    for (int w = 0; w < 16; w++) do_read(32'(w) << 2, "init_rd");
`endif
  endtask

  task automatic test_byte_write;
    do_write(32'h0000_000C, 4'hF, 32'h1122_3344);
    do_write(32'h0000_0008, 4'hF, 32'h0F0F_0F0F);
    do_write(32'h0000_000C, 4'b0101, 32'hAABB_CCDD);
    do_read(32'h0000_000C, "bytew");
    n_total++;
    if (dout !== 32'h11BB_33DD) $display("FAIL bytew_lit got=%h exp=11bb33dd", dout);
    else n_pass++;
    do_read(32'h0000_0008, "bytew_nbr");
  endtask

  task automatic test_back_to_back;
    do_write(32'h0000_0010, 4'hF, 32'hDEAD_BEEF);
    do_read(32'h0000_0010, "b2b");
    n_total++;
    if (dout !== 32'hDEAD_BEEF) $display("FAIL b2b_lit got=%h exp=deadbeef", dout);
    else n_pass++;
    step;
    n_total++;
    if (rvalid !== 1'b0) $display("FAIL b2b_rvalid_once got=%b exp=0", rvalid);
    else n_pass++;
    do_write(32'h0000_0024, 4'hF, 32'hCAFE_F00D);
    do_read(32'h0000_0024, "cafe");
    n_total++;
    if (dout !== 32'hCAFE_F00D) $display("FAIL cafe_lit got=%h exp=cafef00d", dout);
    else n_pass++;
  endtask

  task automatic test_alias;
    do_write(32'h0000_0040, 4'hF, 32'h0000_0005);
    do_read(32'h0000_0000, "alias");
    n_total++;
    if (dout !== 32'h0000_0005) $display("FAIL alias_lit got=%h exp=5", dout);
    else n_pass++;
    do_write(32'hF000_0037, 4'hF, 32'h7777_1234);
    do_read(32'h0000_0034, "alias_hi");
  endtask

`ifdef SRAM_BW_INIT_EN
  task automatic test_reset_mid_sweep;
    rst = 1'b1;
    step;
    rst = 1'b0;
    repeat (7) step;
    rst = 1'b1;
    step;
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      n_total++;
      if (rdy !== 1'b0) $display("FAIL resweep_rdy_low cyc=%0d got=%b exp=0", i, rdy);
      else n_pass++;
      if (i == 10) begin
        en = 1'b1; we = 4'hF; adr = 32'h0000_0008; din = 32'h1234_5678;
      end else if (i == 12) begin
        en = 1'b1; we = 4'h0; adr = 32'h0000_0024;
      end
      step;
      en = 1'b0; we = 4'h0;
      n_total++;
      if (rvalid !== 1'b0) $display("FAIL resweep_rvalid cyc=%0d got=%b exp=0", i, rvalid);
      else n_pass++;
    end
    n_total++;
    if (rdy !== 1'b1) $display("FAIL resweep_rdy_high got=%b exp=1", rdy);
    else n_pass++;
    n_total++;
    if (dout !== IV) $display("FAIL resweep_dout got=%h exp=%h", dout, IV);
    else n_pass++;
    for (int w = 0; w < 16; w++) model[w] = IV;
    do_read(32'h0000_0008, "resweep_w2");
    do_read(32'h0000_0024, "resweep_w9");
    do_read(32'h0000_003C, "resweep_w15");
  endtask
`endif

  initial begin
    test_reset;
    test_init;
    test_byte_write;
    test_back_to_back;
    test_alias;
`ifdef SRAM_BW_INIT_EN
    test_reset_mid_sweep;
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/sram_bw.md
SRAM_BW -- requirements
Module: sram_bw

Interface
REQ-001 SHALL have parameter DW, default 32: data width in bits, a multiple of 8, minimum 8.
REQ-002 SHALL have parameter AW, default 14: word-address width, giving depth 2^AW words.
REQ-003 SHALL have parameter ALSB, default 2: bit index of the word-address LSB within adr.
REQ-004 SHALL have parameter INIT_VAL, default 0: DW-bit value written to every word by the init sweep.
REQ-005 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL have port en, input, 1 bit: access request.
REQ-008 SHALL have port we, input, DW/8 bits: per-byte write enables; all-zero means read.
REQ-009 SHALL have port adr, input, 32 bits: byte address; the word index is adr[ALSB+AW-1:ALSB].
REQ-010 SHALL have port din, input, DW bits: write data, lane i = din[8i+7:8i].
REQ-011 SHALL have port dout, output, DW bits: contents of the word at the registered address.
REQ-012 SHALL have port rdy, output, 1 bit: the block accepts accesses.
REQ-013 SHALL have port rvalid, output, 1 bit: dout holds data for a read accepted on the previous cycle.

Function
REQ-014 SHALL accept an access on a rising edge where en and rdy are both 1; no other edge accepts an access.
REQ-015 On acceptance, SHALL write each byte lane i with we[i]=1 into the word at the decoded index; lanes with we[i]=0 are unchanged.
REQ-016 On acceptance, SHALL load the registered address adr_r with the decoded word index, whether the access is a read or a write.
REQ-017 SHALL drive dout combinationally as mem[adr_r]; read latency is one cycle from acceptance.
REQ-018 SHALL hold adr_r when no access is accepted, so dout tracks later writes to that word.
REQ-019 Read-after-write to the same word on consecutive cycles: dout in the later cycle SHALL show the merged new bytes.
REQ-020 SHALL assert rvalid for exactly one cycle after each accepted access with we all zero, else 0.
REQ-021 SHALL ignore adr bits outside [ALSB+AW-1:ALSB], so addresses alias modulo 2^AW words.
REQ-022 SHALL use FSM states INIT and READY: rst -> INIT; INIT -> READY after the last sweep write; READY -> READY until rst.
REQ-023 In INIT, SHALL write INIT_VAL to word cnt each cycle, with cnt counting from 0; after writing cnt = 2^AW-1 it SHALL enter READY and SHALL NOT wrap.
REQ-024 rdy SHALL equal (state == READY); en and we SHALL be ignored in INIT.

Reset
REQ-025 While rst=1: state=INIT, cnt=0, adr_r=0, rvalid=0, rdy=0; memory contents SHALL NOT be reset directly.
REQ-026 rst asserted mid-sweep or mid-operation SHALL restart the sweep from word 0 on the first cycle after rst deasserts.
REQ-027 dout SHALL equal mem[0] after reset; it is not guaranteed equal to INIT_VAL until word 0 has been swept.

Configuration
REQ-028 Macro SRAM_BW_INIT_EN defined: the INIT sweep SHALL be built per REQ-022..024, and rdy rises 2^AW cycles after rst deasserts.
REQ-029 SRAM_BW_INIT_EN undefined: no sweep counter; the FSM SHALL enter READY on the first edge after rst deasserts, with memory contents undefined.

Verification
REQ-030 Init, macro on, AW=4: deassert rst -> rdy=0 for 16 cycles then 1; reading each word 0..15 returns INIT_VAL.
REQ-031 Byte write: word 3 = 0x11223344; write we=4'b0101 din=0xAABBCCDD -> next-cycle read of word 3 returns 0x11BB33DD.
REQ-032 Back-to-back: write 0xDEADBEEF at adr 0x10, then read adr 0x10 next cycle -> dout=0xDEADBEEF, rvalid=1 for one cycle only.
REQ-033 Aliasing, AW=4: write 0x5 at adr 0x40 -> read at adr 0x00 returns 0x5; en during INIT leaves memory and adr_r unchanged.
REQ-034 Reset at sweep cnt=7 -> cnt restarts at 0, rdy stays 0 for a full 16 cycles after rst deasserts.
REQ-035 Macro off: rdy=1 on the second cycle after rst deasserts; a write then read of 0xCAFEF00D returns 0xCAFEF00D.
